// File: rtl/scfifo_rr_drain_arbiter.sv
// Round-robin drain scheduler: pops NUM_REQ show-ahead FIFOs into one registered valid/ready stream.
// Optional per-source pop counters (word_count, stats_clr) when SCFIFO_RR_ARB_STATS_EN is defined.
module scfifo_rr_drain_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int SRC_W   = $clog2(NUM_REQ),
  parameter int WIDTH   = 20,
  parameter int BURST   = 4,
  parameter int BURST_W = 8
) (
  input  logic                     clock,
  input  logic                     sclr,
  input  logic [NUM_REQ-1:0]       fifo_empty,
  input  logic [NUM_REQ*WIDTH-1:0] fifo_q,
  output logic [NUM_REQ-1:0]       fifo_rdreq,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_data,
  output logic [SRC_W-1:0]         out_src,
  input  logic                     out_ready,
  output logic                     busy
`ifdef SCFIFO_RR_ARB_STATS_EN
  ,
  input  logic                     stats_clr,
  output logic [NUM_REQ*16-1:0]    word_count
`endif
);

  typedef enum logic [0:0] {IDLE, GRANT} state_t;

  state_t             state_reg;
  logic [SRC_W-1:0]   owner_reg;
  logic [SRC_W-1:0]   last_owner_reg;
  logic [BURST_W-1:0] burst_cnt_reg;
  logic [BURST_W-1:0] burst_cnt_next;
  logic               can_load;
  logic               winner_found;
  logic [SRC_W-1:0]   winner;
  logic               pop_en;
  logic [SRC_W-1:0]   pop_idx;

  assign can_load       = ~out_valid | out_ready;
  assign burst_cnt_next = burst_cnt_reg + BURST_W'(1);
  assign busy           = (state_reg != IDLE);

  // Scan from the farthest offset down so the nearest non-empty index after last_owner wins.
  always_comb begin
    winner       = '0;
    winner_found = 1'b0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (!fifo_empty[(int'(last_owner_reg) + k) % NUM_REQ]) begin
        winner       = SRC_W'((int'(last_owner_reg) + k) % NUM_REQ);
        winner_found = 1'b1;
      end
    end
  end

  always_comb begin
    pop_en  = 1'b0;
    pop_idx = owner_reg;
    if (!sclr) begin
      if (state_reg == IDLE) begin
        pop_en  = winner_found & can_load;
        pop_idx = winner;
      end else begin
        pop_en  = ~fifo_empty[owner_reg] & can_load;
      end
    end
  end

  always_comb begin
    fifo_rdreq = '0;
    if (pop_en) fifo_rdreq[pop_idx] = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (sclr) begin
      out_valid      <= 1'b0;
      out_data       <= '0;
      out_src        <= '0;
      state_reg      <= IDLE;
      burst_cnt_reg  <= '0;
      last_owner_reg <= SRC_W'(NUM_REQ - 1);
      owner_reg      <= '0;
    end else begin
      if (pop_en) begin
        out_valid <= 1'b1;
        out_data  <= fifo_q[pop_idx*WIDTH +: WIDTH];
        out_src   <= pop_idx;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      case (state_reg)
        IDLE: begin
          if (pop_en) begin
            owner_reg      <= winner;
            last_owner_reg <= winner;
            burst_cnt_reg  <= BURST_W'(1);
            state_reg      <= (BURST == 1) ? IDLE : GRANT;
          end
        end
        GRANT: begin
          // An empty owner ends the grant early; this is the only bubble in the stream.
          if (fifo_empty[owner_reg]) begin
            state_reg <= IDLE;
          end else if (pop_en) begin
            burst_cnt_reg <= burst_cnt_next;
            if (burst_cnt_next == BURST_W'(BURST)) state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

`ifdef SCFIFO_RR_ARB_STATS_EN
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_stats
      logic [15:0] count_reg;
      always_ff @(posedge clock) begin
        if (sclr || stats_clr) begin
          count_reg <= '0;
        end else if (fifo_rdreq[gi] && (count_reg != 16'hFFFF)) begin
          count_reg <= count_reg + 16'd1;
        end
      end
      assign word_count[gi*16 +: 16] = count_reg;
    end
  endgenerate
`endif

endmodule
